// File: rtl/pipelined_barrel_shifter_if.sv
// rtl/pipelined_barrel_shifter_if.sv - valid/ready bundle for the pipelined barrel shifter
interface pipelined_barrel_shifter_if #(
    parameter int WIDTH = 8
) ();
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] data_in;
    logic [SHW-1:0]   shift_amt;
    logic             left_right;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] data_out;

    modport master (
        output in_valid, data_in, shift_amt, left_right, mode, out_ready,
        input  in_ready, out_valid, data_out
    );

    modport slave (
        input  in_valid, data_in, shift_amt, left_right, mode, out_ready,
        output in_ready, out_valid, data_out
    );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// rtl/pipelined_barrel_shifter.sv - SHW-stage rotate/shift pipeline, sign fill under PIPELINED_BARREL_SHIFTER_ARITH_EN
module pipelined_barrel_shifter #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    pipelined_barrel_shifter_if.slave   bus
);
    if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("WIDTH must be a power of two, at least 4");
    end

    // Stage registers: data already shifted by the stages up to k, plus the
    // per-word controls that travel with it.
    logic [WIDTH-1:0] st_d   [SHW];
    logic [SHW-1:0]   st_amt [SHW];
    logic [1:0]       st_m   [SHW];
    logic [SHW-1:0]   st_lr;
    logic [SHW-1:0]   st_v;

    // What each stage would load: the input word for stage 0, the previous
    // stage otherwise.
    logic [WIDTH-1:0] src_d   [SHW];
    logic [SHW-1:0]   src_amt [SHW];
    logic [1:0]       src_m   [SHW];
    logic [SHW-1:0]   src_lr;
    logic [SHW-1:0]   src_v;
    logic [SHW-1:0]   rdy;

    // One power-of-two step; s is a per-stage constant after unrolling.
    function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                    input int s,
                                                    input logic [1:0] m,
                                                    input logic lr);
        logic [WIDTH-1:0] r;
        r = d;
        case (m)
            2'b00:   r = lr ? ((d << s) | (d >> (WIDTH - s))) : ((d >> s) | (d << (WIDTH - s)));
            2'b01:   r = lr ? (d << s) : (d >> s);
`ifdef PIPELINED_BARREL_SHIFTER_ARITH_EN
            2'b10:   r = lr ? (d << s) : unsigned'($signed(d) >>> s);
`else
            2'b10:   r = lr ? (d << s) : (d >> s);
`endif
            default: r = d;
        endcase
        return r;
    endfunction

    // Stage sources and the ready chain, walked back from the output so a
    // full pipeline can still accept when the last stage drains.
    always_comb begin
        logic nxt;
        src_v[0]   = bus.in_valid;
        src_d[0]   = bus.data_in;
        src_amt[0] = bus.shift_amt;
        src_m[0]   = bus.mode;
        src_lr[0]  = bus.left_right;
        for (int k = 1; k < SHW; k++) begin
            src_v[k]   = st_v[k-1];
            src_d[k]   = st_d[k-1];
            src_amt[k] = st_amt[k-1];
            src_m[k]   = st_m[k-1];
            src_lr[k]  = st_lr[k-1];
        end
        nxt = bus.out_ready;
        rdy = '0;
        for (int k = SHW - 1; k >= 0; k--) begin
            rdy[k] = !st_v[k] || nxt;
            nxt    = rdy[k];
        end
    end

    // Advance every stage that is empty or whose contents move on; the
    // payload only loads alongside a valid word so a held output stays put.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_v  <= '0;
            st_lr <= '0;
            for (int k = 0; k < SHW; k++) begin
                st_d[k]   <= '0;
                st_amt[k] <= '0;
                st_m[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < SHW; k++) begin
                if (rdy[k]) begin
                    st_v[k] <= src_v[k];
                    if (src_v[k]) begin
                        st_d[k]   <= src_amt[k][k] ? shift_step(src_d[k], 1 << k, src_m[k], src_lr[k])
                                                   : src_d[k];
                        st_amt[k] <= src_amt[k];
                        st_m[k]   <= src_m[k];
                        st_lr[k]  <= src_lr[k];
                    end
                end
            end
        end
    end

    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = st_v[SHW-1];
    assign bus.data_out  = st_d[SHW-1];
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb/tb_pipelined_barrel_shifter.sv - randomized scoreboard bench for pipelined_barrel_shifter
module tb_pipelined_barrel_shifter;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   n_acc = 0;
    int   n_emit = 0;
    logic [W-1:0] q[$];

    pipelined_barrel_shifter_if #(.WIDTH(W)) bus ();

    pipelined_barrel_shifter #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: each output bit picked from the input by the shift rules.
    function automatic logic [W-1:0] ref_op(input logic [W-1:0] d, input int n,
                                            input logic lr, input logic [1:0] m);
        logic [W-1:0] r;
        logic fill;
`ifdef PIPELINED_BARREL_SHIFTER_ARITH_EN
        fill = (m == 2'b10) ? d[W-1] : 1'b0;
`else
        fill = 1'b0;
`endif
        for (int i = 0; i < W; i++) begin
            case (m)
                2'b00:   r[i] = lr ? d[(i - n + W) % W] : d[(i + n) % W];
                2'b11:   r[i] = d[i];
                default: begin
                    if (lr) r[i] = (i >= n) ? d[i - n] : 1'b0;
                    else    r[i] = (i + n < W) ? d[i + n] : fill;
                end
            endcase
        end
        return r;
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] d, input int n,
                         input logic lr, input logic [1:0] m);
        bus.in_valid   = v;
        bus.data_in    = d;
        bus.shift_amt  = n[2:0];
        bus.left_right = lr;
        bus.mode       = m;
    endtask

    // Called at a falling edge with inputs set: record the transfers the
    // next rising edge will make, then move to the following falling edge.
    task automatic tick();
        #1;
        if (bus.out_valid && bus.out_ready) begin
            n_emit++;
            if (q.size() == 0) check("unexpected_out", bus.data_out, 32'hdead);
            else check("sb_data", bus.data_out, q.pop_front());
        end
        if (bus.in_valid && bus.in_ready) begin
            n_acc++;
            q.push_back(ref_op(bus.data_in, int'(bus.shift_amt), bus.left_right, bus.mode));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 50 && q.size() != 0; c++) tick();
        check(tag, q.size(), 0);
    endtask

    task automatic directed(input string tag, input logic [W-1:0] d, input int n,
                            input logic lr, input logic [1:0] m, input logic [W-1:0] exp);
        int lat;
        lat = 0;
        bus.out_ready = 1'b1;
        drive(1'b1, d, n, lr, m);
        tick();
        drive(1'b0, '0, 0, 1'b0, 2'b00);
        for (int c = 1; c <= 10; c++) begin
            if (bus.out_valid) begin
                lat = c;
                break;
            end
            tick();
        end
        check({tag, "_lat"}, lat, 3);
        check(tag, bus.data_out, exp);
        drain({tag, "_drain"});
    endtask

    initial begin
        logic [W-1:0] held;
        logic [W-1:0] cur;
        int a0, e0;
        rst_n = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b1, 8'hff, 7, 1'b1, 2'b00);
        @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_data_out", bus.data_out, 0);
        rst_n = 1'b1;
        drive(1'b0, '0, 0, 1'b0, 2'b00);
        #1;
        check("first_in_ready", bus.in_ready, 1);
        @(negedge clk);

        directed("rotl3", 8'h96, 3, 1'b1, 2'b00, 8'hB4);
        directed("rotr1", 8'h96, 1, 1'b0, 2'b00, 8'h4B);
        directed("lsr4",  8'h96, 4, 1'b0, 2'b01, 8'h09);
        directed("lsl4",  8'h96, 4, 1'b1, 2'b01, 8'h60);
        directed("pass5", 8'h96, 5, 1'b0, 2'b11, 8'h96);
        directed("amt0",  8'h96, 0, 1'b0, 2'b00, 8'h96);
`ifdef PIPELINED_BARREL_SHIFTER_ARITH_EN
        directed("asr2",  8'h96, 2, 1'b0, 2'b10, 8'hE5);
`else
        directed("asr2",  8'h96, 2, 1'b0, 2'b10, 8'h25);
`endif

        // Backpressure: six cycles of offered words, nothing drained.
        bus.out_ready = 1'b0;
        a0 = n_acc;
        cur = 8'h11;
        held = '0;
        drive(1'b1, cur, 1, 1'b1, 2'b00);
        for (int c = 0; c < 6; c++) begin
            if (bus.out_valid) begin
                if (held != '0) check("stall_stable", bus.data_out, held);
                held = bus.data_out;
            end
            #1;
            if (bus.in_ready) begin
                cur = cur + 8'h22;
                tick();
                drive(1'b1, cur, 1, 1'b1, 2'b00);
            end else begin
                tick();
            end
        end
        check("stall_accepts", n_acc - a0, 3);
        check("stall_in_ready", bus.in_ready, 0);
        drain("stall_drain");

        // Full pipeline streaming with both sides open.
        bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, W'($urandom), $urandom_range(0, 7), 1'($urandom), 2'($urandom));
            tick();
        end
        a0 = n_acc;
        e0 = n_emit;
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, W'($urandom), $urandom_range(0, 7), 1'($urandom), 2'($urandom));
            tick();
        end
        check("stream_acc", n_acc - a0, 10);
        check("stream_emit", n_emit - e0, 10);
        drain("stream_drain");

        // Random traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom), W'($urandom), $urandom_range(0, 7), 1'($urandom), 2'($urandom));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain("rand_drain");

        // Asynchronous reset with words in flight.
        bus.out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 8'hA5, 0, 1'b0, 2'b11);
            tick();
        end
        check("pre_rst_valid", bus.out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_out_valid", bus.out_valid, 0);
        check("async_data_out", bus.data_out, 0);
        q.delete();
        @(posedge clk);
        @(negedge clk);
        check("rst_ignores_in", bus.out_valid, 0);
        rst_n = 1'b1;
        drive(1'b0, '0, 0, 1'b0, 2'b00);
        bus.out_ready = 1'b1;
        #1;
        check("post_rst_in_ready", bus.in_ready, 1);
        @(negedge clk);
        for (int c = 0; c < 6; c++) tick();
        directed("post_rst_rotl3", 8'h96, 3, 1'b1, 2'b00, 8'hB4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
